// File: rtl/phy_link_monitor.sv
// rtl/phy_link_monitor.sv - MDIO PHY sequencer: init writes, periodic BMSR/PHYSR polling, link/speed/duplex status
// Optional build macro PHY_MON_DISABLE_1G_EN adds a GBCR write that clears 1000BASE-T advertisement at init.
module phy_link_monitor #(
  parameter logic [4:0]  PHY_ADDR      = 5'h00,
  parameter int unsigned INIT_DELAY    = 65535,
  parameter int unsigned POLL_INTERVAL = 1250000,
  parameter int unsigned RSP_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  input  logic        restart_an,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        full_duplex,
  output logic        status_valid,
  output logic        link_change,
  output logic        rsp_timeout
);

  localparam logic [1:0]  OP_WRITE        = 2'b01;
  localparam logic [1:0]  OP_READ         = 2'b10;
  localparam logic [4:0]  REG_BMCR        = 5'h00;
  localparam logic [4:0]  REG_BMSR        = 5'h01;
  localparam logic [4:0]  REG_PHYSR       = 5'h11;
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1340;
  localparam logic [31:0] POLL_RELOAD     = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] TIMEOUT_LAST    = 32'(RSP_TIMEOUT - 1);
`ifdef PHY_MON_DISABLE_1G_EN
  localparam logic [4:0]  REG_GBCR        = 5'h09;
`endif

  typedef enum logic [2:0] {
    S_INIT_WAIT  = 3'd0,
`ifdef PHY_MON_DISABLE_1G_EN
    S_WR_GBCR    = 3'd1,
`endif
    S_WR_BMCR    = 3'd2,
    S_IDLE       = 3'd3,
    S_RD_BMSR    = 3'd4,
    S_WAIT_BMSR  = 3'd5,
    S_RD_PHYSR   = 3'd6,
    S_WAIT_PHYSR = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] cnt;
  logic        cmd_state;
  logic        cmd_fire;
  logic        wait_state;
  logic        timeout_hit;
  logic [4:0]  req_reg;
  logic [15:0] req_data;
  logic [1:0]  req_op;
  logic        bmsr_link;
  logic        unused_data_bits;

  assign cmd_phy_addr     = PHY_ADDR;
  assign data_in_ready    = 1'b1;
  assign unused_data_bits = ^{data_in[12:3], data_in[1:0]};

  assign cmd_fire    = cmd_valid & cmd_ready;
  assign wait_state  = (state == S_WAIT_BMSR) || (state == S_WAIT_PHYSR);
  // Data arriving on the last allowed cycle still counts as a response.
  assign timeout_hit = wait_state && !data_in_valid && (cnt == TIMEOUT_LAST);

  always_comb begin
    state_nx  = state;
    cmd_state = 1'b0;
    req_reg   = REG_BMSR;
    req_data  = 16'h0000;
    req_op    = OP_READ;
    case (state)
      S_INIT_WAIT: begin
        if (cnt == 32'd0) begin
`ifdef PHY_MON_DISABLE_1G_EN
          state_nx = S_WR_GBCR;
`else
          state_nx = S_IDLE;
`endif
        end
      end
`ifdef PHY_MON_DISABLE_1G_EN
      S_WR_GBCR: begin
        cmd_state = 1'b1;
        req_reg   = REG_GBCR;
        req_op    = OP_WRITE;
        if (cmd_fire) state_nx = S_WR_BMCR;
      end
`endif
      S_WR_BMCR: begin
        cmd_state = 1'b1;
        req_reg   = REG_BMCR;
        req_data  = BMCR_AN_RESTART;
        req_op    = OP_WRITE;
        if (cmd_fire) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (restart_an) state_nx = S_WR_BMCR;
        else if (cnt == 32'd0) state_nx = S_RD_BMSR;
      end
      S_RD_BMSR: begin
        cmd_state = 1'b1;
        if (cmd_fire) state_nx = S_WAIT_BMSR;
      end
      S_WAIT_BMSR: begin
        if (data_in_valid) state_nx = S_RD_PHYSR;
        else if (timeout_hit) state_nx = S_IDLE;
      end
      S_RD_PHYSR: begin
        cmd_state = 1'b1;
        req_reg   = REG_PHYSR;
        if (cmd_fire) state_nx = S_WAIT_PHYSR;
      end
      S_WAIT_PHYSR: begin
        if (data_in_valid || timeout_hit) state_nx = S_IDLE;
      end
      default: state_nx = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT_WAIT;
    else        state <= state_nx;
  end

  // One counter serves init delay, poll interval (both down) and response timeout (up).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'(INIT_DELAY);
    end else if (state_nx != state) begin
      if (state_nx == S_IDLE) cnt <= POLL_RELOAD;
      else                    cnt <= 32'd0;
    end else if (wait_state) begin
      cnt <= cnt + 32'd1;
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid    <= 1'b0;
      cmd_reg_addr <= 5'd0;
      cmd_data     <= 16'h0000;
      cmd_opcode   <= OP_READ;
    end else if (cmd_fire) begin
      cmd_valid <= 1'b0;
    end else if (cmd_state && !cmd_valid) begin
      cmd_valid    <= 1'b1;
      cmd_reg_addr <= req_reg;
      cmd_data     <= req_data;
      cmd_opcode   <= req_op;
    end
  end

  // BMSR link bit is parked until PHYSR arrives so all status outputs move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmsr_link    <= 1'b0;
      link_up      <= 1'b0;
      speed        <= 2'b00;
      full_duplex  <= 1'b0;
      status_valid <= 1'b0;
      link_change  <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      link_change <= 1'b0;
      rsp_timeout <= 1'b0;
      if (state == S_WAIT_BMSR && data_in_valid) begin
        bmsr_link <= data_in[2];
      end
      if (state == S_WAIT_PHYSR && data_in_valid) begin
        link_up      <= bmsr_link;
        speed        <= data_in[15:14];
        full_duplex  <= data_in[13];
        status_valid <= 1'b1;
        link_change  <= bmsr_link ^ link_up;
      end
      if (timeout_hit) begin
        rsp_timeout  <= 1'b1;
        status_valid <= 1'b0;
        link_up      <= 1'b0;
        link_change  <= link_up;
      end
    end
  end

endmodule

// File: tb/tb_phy_link_monitor.sv
// tb/tb_phy_link_monitor.sv - self-checking bench for phy_link_monitor
module tb_phy_link_monitor;

  localparam logic [4:0] P_ADDR = 5'h03;
  localparam int INIT_D = 16;
  localparam int PI     = 200;
  localparam int RT     = 64;
  localparam int LIMIT  = INIT_D + PI + RT + 100;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
`ifdef PHY_MON_DISABLE_1G_EN
  localparam bit GBCR_EN = 1'b1;
`else
  localparam bit GBCR_EN = 1'b0;
`endif

  typedef struct {
    logic       link;
    logic [1:0] speed;
    logic       fd;
    logic       valid;
    logic       lc;
  } st_t;

  typedef struct {
    logic [15:0] bmsr;
    logic [15:0] physr;
    int          stall;
    int          drop;
    int          delay;
    st_t         e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic        restart_an = 1'b0;
  logic        link_up;
  logic [1:0]  speed;
  logic        full_duplex;
  logic        status_valid;
  logic        link_change;
  logic        rsp_timeout;

  int cyc = 0;
  int idle_cyc = 0;
  int errors = 0;
  int checks = 0;
  st_t m;

  phy_link_monitor #(
    .PHY_ADDR(P_ADDR), .INIT_DELAY(INIT_D), .POLL_INTERVAL(PI), .RSP_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .cmd_opcode(cmd_opcode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .restart_an(restart_an), .link_up(link_up), .speed(speed), .full_duplex(full_duplex),
    .status_valid(status_valid), .link_change(link_change), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic st_t predict(input logic [15:0] bmsr, input logic [15:0] physr,
                                  input int drop, input st_t cur);
    st_t e;
    if (drop == 0) begin
      e.link  = bmsr[2];
      e.speed = physr[15:14];
      e.fd    = physr[13];
      e.valid = 1'b1;
      e.lc    = bmsr[2] ^ cur.link;
    end else begin
      e.link  = 1'b0;
      e.speed = cur.speed;
      e.fd    = cur.fd;
      e.valid = 1'b0;
      e.lc    = cur.link;
    end
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd"}, {cmd_valid, cmd_opcode, cmd_reg_addr, cmd_data, data_in_ready, cmd_phy_addr},
        {1'b0, 2'b10, 5'd0, 16'h0000, 1'b1, P_ADDR});
    chk({tag, "_status"}, {link_up, speed, full_duplex, status_valid, link_change, rsp_timeout},
        {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // Waits for cmd_valid while injecting stray read beats that must be discarded.
  task automatic wait_cmd(output bit ok);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < LIMIT) begin
      data_in_valid = ($urandom_range(0, 3) == 0);
      data_in = 16'($urandom);
      @(negedge clk);
      n++;
    end
    data_in_valid = 1'b0;
    ok = (cmd_valid === 1'b1);
    chk("cmd_wait", cmd_valid, 1'b1);
  endtask

  task automatic issue(input logic [4:0] r, input logic [15:0] d, input logic [1:0] op, input int stall);
    chk("cmd_fields", {cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode}, {P_ADDR, r, d, op});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("cmd_stall_hold", {cmd_valid, cmd_reg_addr, cmd_data, cmd_opcode}, {1'b1, r, d, op});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("cmd_valid_drop", cmd_valid, 1'b0);
  endtask

  task automatic respond(input int delay, input logic [15:0] d);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      restart_an = 1'b0;
    end
    data_in = d;
    data_in_valid = 1'b1;
  endtask

  task automatic wait_timeout(input st_t e);
    int n;
    n = 0;
    while (rsp_timeout !== 1'b1 && n < RT + 20) begin
      @(negedge clk);
      restart_an = 1'b0;
      n++;
    end
    chk("timeout_latency", n, RT);
    chk("timeout_status", {status_valid, link_up, link_change, speed, full_duplex},
        {e.valid, e.link, e.lc, e.speed, e.fd});
    idle_cyc = cyc;
    @(negedge clk);
    chk("timeout_pulse_width", {rsp_timeout, link_change}, 2'b00);
  endtask

  task automatic do_poll(input logic [15:0] bmsr, input logic [15:0] physr, input int stall,
                         input int drop, input int delay, input st_t e, input bit rs_in_wait);
    bit ok;
    wait_cmd(ok);
    if (!ok) return;
    chk("poll_period", cyc - idle_cyc, PI + 1);
    issue(5'h01, 16'h0000, OP_RD, stall);
    restart_an = rs_in_wait;
    if (drop == 1) begin
      wait_timeout(e);
      return;
    end
    respond(delay, bmsr);
    @(negedge clk);
    data_in_valid = 1'b0;
    restart_an = 1'b0;
    wait_cmd(ok);
    if (!ok) return;
    chk("bmsr_no_early_update", {link_up, status_valid}, {m.link, m.valid});
    issue(5'h11, 16'h0000, OP_RD, 0);
    if (drop == 2) begin
      wait_timeout(e);
      return;
    end
    respond(delay, physr);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("status_update", {link_up, speed, full_duplex, status_valid, link_change},
        {e.link, e.speed, e.fd, e.valid, e.lc});
    idle_cyc = cyc;
    @(negedge clk);
    chk("link_change_width", link_change, 1'b0);
  endtask

  task automatic init_seq();
    int c0;
    int prev;
    bit ok;
    logic [4:0]  wr_reg[$];
    logic [15:0] wr_dat[$];
    c0 = cyc;
    if (GBCR_EN) begin
      wr_reg = '{5'h09, 5'h00};
      wr_dat = '{16'h0000, 16'h1340};
    end
    prev = c0 + INIT_D + 1;
    idle_cyc = c0 + INIT_D + 1;
    foreach (wr_reg[i]) begin
      wait_cmd(ok);
      if (!ok) return;
      chk("init_cmd_latency", cyc - prev, 1);
      issue(wr_reg[i], wr_dat[i], OP_WR, 0);
      prev = cyc;
      idle_cyc = cyc;
    end
    m = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  endtask

  initial begin
    vec_t tbl[9];
    st_t  e;
    bit   ok;

    tbl[0] = '{16'h796D, 16'h6C00, 0,  0, 3,      '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1}};
    tbl[1] = '{16'h7969, 16'hA000, 0,  0, 0,      '{1'b0, 2'b10, 1'b1, 1'b1, 1'b1}};
    tbl[2] = '{16'h0004, 16'h0000, 50, 0, RT - 1, '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1}};
    tbl[3] = '{16'h0004, 16'h0000, 0,  1, 0,      '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{16'h0004, 16'h4000, 2,  0, 5,      '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1}};
    tbl[5] = '{16'h0000, 16'h0000, 0,  2, 0,      '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{16'h0004, 16'h0000, 0,  2, 0,      '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0}};
    tbl[7] = '{16'hFFFF, 16'hE000, 1,  0, 7,      '{1'b1, 2'b11, 1'b1, 1'b1, 1'b1}};
    tbl[8] = '{16'hFFFF, 16'hE000, 0,  0, 1,      '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0}};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset_values");
    rst_n = 1'b1;
    init_seq();

    for (int i = 0; i < 9; i++) begin
      do_poll(tbl[i].bmsr, tbl[i].physr, tbl[i].stall, tbl[i].drop, tbl[i].delay, tbl[i].e, 1'b0);
      m = tbl[i].e;
    end

    // restart_an on the same cycle the poll timer expires
    while (cyc < idle_cyc + PI - 1) @(negedge clk);
    chk("pre_expiry_quiet", cmd_valid, 1'b0);
    restart_an = 1'b1;
    @(negedge clk);
    restart_an = 1'b0;
    wait_cmd(ok);
    chk("restart_latency", cyc - idle_cyc, PI + 1);
    issue(5'h00, 16'h1340, OP_WR, 0);
    idle_cyc = cyc;

    // restart_an during a WAIT state must not divert the poll
    e = predict(16'h0000, 16'h2000, 0, m);
    do_poll(16'h0000, 16'h2000, 0, 0, 2, e, 1'b1);
    m = e;

    for (int i = 0; i < 24; i++) begin
      logic [15:0] b;
      logic [15:0] p;
      int st;
      int dr;
      int dl;
      bit rs;
      b  = 16'($urandom);
      p  = 16'($urandom);
      st = $urandom_range(0, 4);
      dl = $urandom_range(0, RT - 1);
      dr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      rs = ($urandom_range(0, 3) == 0);
      e  = predict(b, p, dr, m);
      do_poll(b, p, st, dr, dl, e, rs);
      m = e;
    end

    // reset asserted while a read command is waiting for cmd_ready
    e = predict(16'h0004, 16'h2000, 0, m);
    do_poll(16'h0004, 16'h2000, 0, 0, 1, e, 1'b0);
    m = e;
    wait_cmd(ok);
    chk("pre_reset_link", link_up, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid_drop", cmd_valid, 1'b0);
    chk_reset("reset_mid_cmd");
    @(negedge clk);
    chk_reset("reset_held");
    rst_n = 1'b1;
    init_seq();
    e = predict(16'h796D, 16'h6C00, 0, m);
    do_poll(16'h796D, 16'h6C00, 0, 0, 0, e, 1'b0);
    m = e;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
